// File: rtl/qreg_arb_pkg.sv
// rtl/qreg_arb_pkg.sv - shared state and op encodings for the register-bank arbiter
package qreg_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PULSE   = 3'd2,
        RECOVER = 3'd3,
        ACK     = 3'd4
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick, one-hot grant
//   req_i [NREQ-1:0] : pending requests
//   ptr_i [PW-1:0]   : last granted requester; search starts one above it
//   gnt_o [NREQ-1:0] : one-hot grant, all zero when no request
module rr_picker #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    always_comb begin
        int  idx;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        // Walk ptr+1 .. ptr+NREQ modulo NREQ; the last granted one is seen last.
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qreg_arbiter.sv
// rtl/qreg_arbiter.sv - arbitrates requesters onto one shared flip-flop bank
//   QCK, QRT           : clock, asynchronous active-high reset
//   req/op/wdata       : per-requester request, op (00 LOAD 01 SET 10 CLEAR 11 NOP), load data
//   ack                : one-cycle completion pulse per requester
//   bank_en/di/st/rt   : bank clock-enable, data, set, clear
//   busy               : high whenever the FSM is not idle
//   Macro QREG_ARB_PRIO0_EN: requester 0 overrides the round-robin choice.
module qreg_arbiter
    import qreg_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                    QCK,
    input  logic                    QRT,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]         ack,
    output logic                    bank_en,
    output logic [WIDTH-1:0]        bank_di,
    output logic                    bank_st,
    output logic                    bank_rt,
    output logic                    busy
);

    localparam int PW = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    win_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;

    logic [NREQ-1:0]  rr_gnt;
    logic [NREQ-1:0]  gnt;
    logic [PW-1:0]    gnt_idx;
    logic [1:0]       op_sel;

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt)
    );

`ifdef QREG_ARB_PRIO0_EN
    assign gnt = req[0] ? {{(NREQ-1){1'b0}}, 1'b1} : rr_gnt;
`else
    assign gnt = rr_gnt;
`endif

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) gnt_idx = PW'(k);
        end
    end

    assign op_sel = op[2*gnt_idx +: 2];

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ-1);
            win_q   <= '0;
            op_q    <= OP_NOP;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |req) begin
                win_q  <= gnt_idx;
                op_q   <= op_sel;
                data_q <= wdata[gnt_idx*WIDTH +: WIDTH];
            end
            if (state_q == ACK) begin
`ifdef QREG_ARB_PRIO0_EN
                // Priority grants to requester 0 leave the rotation undisturbed.
                if (win_q != '0) ptr_q <= win_q;
`else
                ptr_q <= win_q;
`endif
            end
        end
    end

    // Bank controls decode from state only, so QRT clears them asynchronously.
    always_comb begin
        state_d = state_q;
        ack     = '0;
        bank_en = 1'b0;
        bank_di = '0;
        bank_st = 1'b0;
        bank_rt = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    case (op_sel)
                        OP_LOAD:  state_d = LOAD;
                        OP_SET,
                        OP_CLEAR: state_d = PULSE;
                        default:  state_d = ACK;
                    endcase
                end
            end
            LOAD: begin
                bank_en = 1'b1;
                bank_di = data_q;
                state_d = ACK;
            end
            PULSE: begin
                bank_st = (op_q == OP_SET);
                bank_rt = (op_q == OP_CLEAR);
                state_d = RECOVER;
            end
            RECOVER: state_d = ACK;
            ACK: begin
                ack[win_q] = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_qreg_arbiter.sv
// tb/tb_qreg_arbiter.sv - self-checking bench for qreg_arbiter
module tb_qreg_arbiter;

    localparam logic [1:0] K_LOAD = 2'd0, K_SET = 2'd1, K_CLEAR = 2'd2, K_NOP = 2'd3;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  op;
        logic [31:0] wdata;
        logic [1:0]  kind;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_di;
    } vec_t;

    logic        QCK = 1'b0;
    logic        QRT;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic        bank_en, bank_st, bank_rt, busy;
    logic [7:0]  bank_di;

    int n_cmp = 0;
    int n_err = 0;

    qreg_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .QCK(QCK), .QRT(QRT), .req(req), .op(op), .wdata(wdata),
        .ack(ack), .bank_en(bank_en), .bank_di(bank_di),
        .bank_st(bank_st), .bank_rt(bank_rt), .busy(busy)
    );

    always #5 QCK = ~QCK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] obs();
        return {ack, busy, bank_en, bank_st, bank_rt, bank_di};
    endfunction

    function automatic logic [15:0] expv(input logic [3:0] a, input logic b, input logic en,
                                         input logic st, input logic rt, input logic [7:0] di);
        return {a, b, en, st, rt, di};
    endfunction

    task automatic do_reset();
        @(negedge QCK);
        QRT = 1'b1;
        req = '0;
        @(negedge QCK);
        QRT = 1'b0;
    endtask

    task automatic wait_ack(output logic [3:0] a);
        a = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge QCK);
            if (ack != '0) begin
                a = ack;
                break;
            end
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        req   = v.req;
        op    = v.op;
        wdata = v.wdata;
        @(posedge QCK);
        case (v.kind)
            K_LOAD: begin
                @(negedge QCK); chk($sformatf("vec%0d_load", i), obs(), expv(4'h0, 1, 1, 0, 0, v.exp_di));
                @(negedge QCK); chk($sformatf("vec%0d_ack", i),  obs(), expv(v.exp_ack, 1, 0, 0, 0, 8'h00));
            end
            K_SET, K_CLEAR: begin
                @(negedge QCK); chk($sformatf("vec%0d_pulse", i), obs(),
                                    expv(4'h0, 1, 0, v.kind == K_SET, v.kind == K_CLEAR, 8'h00));
                @(negedge QCK); chk($sformatf("vec%0d_recover", i), obs(), expv(4'h0, 1, 0, 0, 0, 8'h00));
                @(negedge QCK); chk($sformatf("vec%0d_ack", i), obs(), expv(v.exp_ack, 1, 0, 0, 0, 8'h00));
            end
            default: begin
                @(negedge QCK); chk($sformatf("vec%0d_ack", i), obs(), expv(v.exp_ack, 1, 0, 0, 0, 8'h00));
            end
        endcase
        req = '0;
        @(negedge QCK); chk($sformatf("vec%0d_idle", i), obs(), 16'h0000);
    endtask

    initial begin
        vec_t       vecs[7];
        vec_t       v;
        logic [3:0] got;
        logic [3:0] exp_a;
        int         seen;

        vecs[0] = '{4'b0001, 8'hFC, 32'h0000_00A5, K_LOAD,  4'b0001, 8'hA5};
        vecs[1] = '{4'b0010, 8'hF7, 32'h0000_0000, K_SET,   4'b0010, 8'h00};
        vecs[2] = '{4'b0100, 8'hFF, 32'h0000_0000, K_NOP,   4'b0100, 8'h00};
        vecs[3] = '{4'b1000, 8'hBF, 32'h0000_0000, K_CLEAR, 4'b1000, 8'h00};
        vecs[4] = '{4'b0010, 8'hF3, 32'h0000_3C00, K_LOAD,  4'b0010, 8'h3C};
        vecs[5] = '{4'b1000, 8'h3F, 32'hFF00_0000, K_LOAD,  4'b1000, 8'hFF};
        vecs[6] = '{4'b0001, 8'hFD, 32'h0000_0000, K_SET,   4'b0001, 8'h00};

        QRT   = 1'b1;
        req   = '0;
        op    = 8'hFF;
        wdata = '0;
        #2;
        chk("reset_outputs", obs(), 16'h0000);
        repeat (2) @(negedge QCK);
        QRT = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // All four requesting LOAD continuously.
        do_reset();
        req   = 4'b1111;
        op    = 8'h00;
        wdata = 32'h4433_2211;
        for (int k = 0; k < 5; k++) begin
`ifdef QREG_ARB_PRIO0_EN
            exp_a = 4'b0001;
`else
            exp_a = 4'(1 << (k % 4));
`endif
            wait_ack(got);
            chk($sformatf("rotate%0d", k), got, exp_a);
        end
        req = '0;
        repeat (3) @(negedge QCK);
        chk("rotate_idle", obs(), 16'h0000);

        // Reset in the middle of a CLEAR pulse, after requester 1 moved the pointer.
        do_reset();
        v = '{4'b0010, 8'hF3, 32'h0000_5A00, K_LOAD, 4'b0010, 8'h5A};
        run_vec(10, v);
        req = 4'b0100;
        op  = 8'hEF;
        @(posedge QCK);
        @(negedge QCK);
        chk("abort_pulse", obs(), expv(4'h0, 1, 0, 0, 1, 8'h00));
        QRT = 1'b1;
        #1;
        chk("abort_cut", obs(), 16'h0000);
        @(negedge QCK);
        QRT  = 1'b0;
        req  = '0;
        seen = 0;
        repeat (4) begin
            @(negedge QCK);
            if (ack != '0 || busy) seen++;
        end
        chk("abort_no_ack", 32'(seen), 32'd0);
        req = 4'b0101;
        op  = 8'hFC;
        wait_ack(got);
        chk("abort_next_req0", got, 4'b0001);
        req = '0;
        repeat (3) @(negedge QCK);

        // Requester 1 withdraws while requester 0 is being served.
        do_reset();
        req   = 4'b0011;
        op    = 8'hF0;
        wdata = 32'h0000_2211;
        @(posedge QCK);
        @(negedge QCK);
        req = 4'b0001;
        wait_ack(got);
        chk("drop_req0_ack", got, 4'b0001);
        req  = '0;
        seen = 0;
        repeat (8) begin
            @(negedge QCK);
            if (ack != '0 || busy) seen++;
        end
        chk("drop_req1_ignored", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
